// File: rtl/cpu_if.sv
// Instruction fetch bus between the core and the external instruction store.
// The core drives the fetch address; the store returns the word at that address.
interface cpu_if;
    logic [18:0] instruction;
    logic [18:0] pc;

    modport master (input instruction, output pc);
    modport slave  (output instruction, input pc);
endinterface

// File: rtl/cpu.sv
// Single-cycle 19-bit load/store core: 16x19 register file, 256x19 data
// memory and an 8-deep return-address stack. Every instruction retires on
// the edge at which it is sampled; all reads are combinational from state.
module cpu (
    input  logic  clk,
    input  logic  reset,
    cpu_if.master bus
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_MUL  = 5'd2,
        OP_DIV  = 5'd3,
        OP_INC  = 5'd4,
        OP_DEC  = 5'd5,
        OP_AND  = 5'd6,
        OP_OR   = 5'd7,
        OP_XOR  = 5'd8,
        OP_NOT  = 5'd9,
        OP_JMP  = 5'd10,
        OP_BEQ  = 5'd11,
        OP_BNE  = 5'd12,
        OP_CALL = 5'd13,
        OP_RET  = 5'd14,
        OP_LD   = 5'd15,
        OP_ST   = 5'd16,
        OP_LDI  = 5'd17
    } op_e;

    // Architectural state
    logic [18:0] pc_q;
    logic [18:0] regs  [16];
    logic [18:0] stack [8];
    logic [2:0]  sp;
    logic [18:0] dmem  [256];

    // Instruction fields; field overlap between formats is intentional
    logic [18:0] instr;
    op_e         op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [18:0] imm_ext;
    logic [18:0] target_ext;
    logic [18:0] off_ext;

    assign instr      = bus.instruction;
    assign op         = op_e'(instr[18:14]);
    assign rd         = instr[13:10];
    assign rs1        = instr[9:6];
    assign rs2        = instr[5:2];
    assign imm_ext    = {9'd0, instr[9:0]};
    assign target_ext = {5'd0, instr[13:0]};
    assign off_ext    = {{13{instr[5]}}, instr[5:0]};

    // Operand reads. For branches the rd field names ra and rs1 names rb;
    // for stores the rd field names the data register.
    logic [18:0] src_a;
    logic [18:0] src_b;
    logic [18:0] rd_val;
    logic [18:0] pc_plus1;
    logic [18:0] pc_branch;
    logic [2:0]  sp_dec;

    assign src_a     = regs[rs1];
    assign src_b     = regs[rs2];
    assign rd_val    = regs[rd];
    assign pc_plus1  = pc_q + 19'd1;
    assign pc_branch = pc_q + off_ext;
    assign sp_dec    = sp - 3'd1;

    // Control and datapath results for the current instruction
    logic [18:0] nxt_pc;
    logic        rf_we;
    logic [18:0] rf_wd;
    logic        mem_we;
    logic        push;
    logic        pop;

    // Decode/execute: compute writeback value, next pc and side effects
    always_comb begin
        nxt_pc = pc_plus1;
        rf_we  = 1'b0;
        rf_wd  = '0;
        mem_we = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        case (op)
            OP_ADD: begin rf_we = 1'b1; rf_wd = src_a + src_b; end
            OP_SUB: begin rf_we = 1'b1; rf_wd = src_a - src_b; end
            OP_MUL: begin rf_we = 1'b1; rf_wd = src_a * src_b; end
            OP_DIV: begin
                rf_we = 1'b1;
                // Divide by zero saturates to all ones instead of trapping
                rf_wd = (src_b == '0) ? 19'h7FFFF : src_a / src_b;
            end
            OP_INC: begin rf_we = 1'b1; rf_wd = src_a + 19'd1; end
            OP_DEC: begin rf_we = 1'b1; rf_wd = src_a - 19'd1; end
            OP_AND: begin rf_we = 1'b1; rf_wd = src_a & src_b; end
            OP_OR:  begin rf_we = 1'b1; rf_wd = src_a | src_b; end
            OP_XOR: begin rf_we = 1'b1; rf_wd = src_a ^ src_b; end
            OP_NOT: begin rf_we = 1'b1; rf_wd = ~src_a; end
            OP_JMP: nxt_pc = target_ext;
            OP_BEQ: if (rd_val == src_a) nxt_pc = pc_branch;
            OP_BNE: if (rd_val != src_a) nxt_pc = pc_branch;
            OP_CALL: begin
                push   = 1'b1;
                nxt_pc = target_ext;
            end
            OP_RET: begin
                // Pop pre-decrements, so the return address lives at sp-1
                pop    = 1'b1;
                nxt_pc = stack[sp_dec];
            end
            OP_LD:  begin rf_we = 1'b1; rf_wd = dmem[src_a[7:0]]; end
            OP_ST:  mem_we = 1'b1;
            OP_LDI: begin rf_we = 1'b1; rf_wd = imm_ext; end
            default: ;
        endcase
    end

    // pc, register file and return stack; async reset clears all of them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            sp   <= '0;
            for (int i = 0; i < 16; i++) regs[i]  <= '0;
            for (int i = 0; i < 8; i++)  stack[i] <= '0;
        end else begin
            pc_q <= nxt_pc;
            if (rf_we) regs[rd] <= rf_wd;
            if (push) begin
                stack[sp] <= pc_plus1;
                sp        <= sp + 3'd1;
            end else if (pop) begin
                sp <= sp_dec;
            end
        end
    end

    // Data memory has no reset; a store is dropped if reset is low at the edge
    always_ff @(posedge clk) begin
        if (mem_we && reset) dmem[src_a[7:0]] <= rd_val;
    end

    assign bus.pc = pc_q;

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: instruction store array, ISA-level reference model stepped
// every edge, per-cycle pc/register compare, plus literal expectations.
module tb_cpu;

    logic clk;
    logic reset;
    cpu_if bus ();

    logic [18:0] imem [0:1023];
    assign bus.instruction = (bus.pc < 19'd1024) ? imem[bus.pc[9:0]] : 19'd0;

    cpu dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoders
    function automatic logic [18:0] r_op(input int op, input int d, input int a, input int b);
        logic [4:0] o; logic [3:0] x, y, z;
        o = 5'(op); x = 4'(d); y = 4'(a); z = 4'(b);
        return {o, x, y, z, 2'b00};
    endfunction
    function automatic logic [18:0] ldi(input int d, input int imm);
        logic [3:0] x; logic [9:0] v;
        x = 4'(d); v = 10'(imm);
        return {5'd17, x, v};
    endfunction
    function automatic logic [18:0] jt(input int op, input int tgt);
        logic [4:0] o; logic [13:0] t;
        o = 5'(op); t = 14'(tgt);
        return {o, t};
    endfunction
    function automatic logic [18:0] br(input int op, input int a, input int b, input int off);
        logic [4:0] o; logic [3:0] x, y; logic [5:0] f;
        o = 5'(op); x = 4'(a); y = 4'(b); f = 6'(off);
        return {o, x, y, f};
    endfunction

    // Reference model: architectural state evolved instruction by instruction
    logic [18:0] m_pc;
    logic [18:0] m_r   [16];
    logic [18:0] m_mem [256];
    logic [18:0] m_stk [8];
    int          m_sp;

    initial for (int i = 0; i < 256; i++) m_mem[i] = '0;

    task automatic model_step(input logic [18:0] ins);
        int op, d; logic [18:0] a, b, npc;
        op  = int'(ins[18:14]);
        d   = int'(ins[13:10]);
        a   = m_r[ins[9:6]];
        b   = m_r[ins[5:2]];
        npc = m_pc + 19'd1;
        case (op)
            0:  m_r[d] = a + b;
            1:  m_r[d] = a - b;
            2:  m_r[d] = 19'((38'(a) * 38'(b)) % 38'h80000);
            3:  m_r[d] = (b == 0) ? 19'h7FFFF : a / b;
            4:  m_r[d] = a + 19'd1;
            5:  m_r[d] = a - 19'd1;
            6:  m_r[d] = a & b;
            7:  m_r[d] = a | b;
            8:  m_r[d] = a ^ b;
            9:  m_r[d] = ~a;
            10: npc = 19'(ins[13:0]);
            11: if (m_r[d] == a) npc = m_pc + 19'(signed'(ins[5:0]));
            12: if (m_r[d] != a) npc = m_pc + 19'(signed'(ins[5:0]));
            13: begin m_stk[m_sp] = m_pc + 19'd1; m_sp = (m_sp + 1) % 8; npc = 19'(ins[13:0]); end
            14: begin m_sp = (m_sp + 7) % 8; npc = m_stk[m_sp]; end
            15: m_r[d] = m_mem[a[7:0]];
            16: m_mem[a[7:0]] = m_r[d];
            17: m_r[d] = 19'(ins[9:0]);
            default: ;
        endcase
        m_pc = npc;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = '0;
            m_sp = 0;
            for (int i = 0; i < 16; i++) m_r[i] = '0;
            for (int i = 0; i < 8; i++)  m_stk[i] = '0;
        end else begin
            model_step((m_pc < 19'd1024) ? imem[m_pc[9:0]] : 19'd0);
        end
    end

    // Per-cycle compare of pc and every register against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("pc", dut.pc_q, m_pc);
            for (int i = 0; i < 16; i++) check($sformatf("R%0d", i), dut.regs[i], m_r[i]);
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = 19'h7C000; // opcode 31 NOP
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, then release on a falling edge
    task automatic pulse_reset_then_release();
        @(posedge clk); #2 reset = 1'b0;
        #1;
        check("async_rst_pc", dut.pc_q, 19'd0);
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        // ALU program
        clear_imem();
        imem[0]  = ldi(1, 5);
        imem[1]  = ldi(2, 3);
        imem[2]  = r_op(0, 3, 1, 2);
        imem[3]  = r_op(1, 4, 1, 2);
        imem[4]  = r_op(2, 5, 1, 2);
        imem[5]  = r_op(3, 6, 1, 2);
        imem[6]  = r_op(3, 8, 1, 0);
        imem[7]  = r_op(1, 7, 2, 1);
        imem[8]  = r_op(4, 9, 1, 0);
        imem[9]  = r_op(5, 10, 2, 0);
        imem[10] = r_op(6, 11, 1, 2);
        imem[11] = r_op(7, 12, 1, 2);
        imem[12] = r_op(8, 13, 1, 2);
        imem[13] = r_op(9, 14, 1, 0);
        imem[14] = ldi(15, 1023);
        imem[15] = r_op(2, 15, 15, 15);
        imem[16] = 19'h7FFFF;          // opcode 31 with junk fields: NOP
        imem[17] = jt(10, 17);

        #2 chk_on = 1;
        // Reset held across edges with a live instruction word
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("rst_hold_pc", dut.pc_q, 19'd0);
        end
        @(negedge clk) reset = 1'b1;
        tick(1);
        check("release_pc", dut.pc_q, 19'd1);
        tick(17);
        check("add",    dut.regs[3],  19'd8);
        check("sub",    dut.regs[4],  19'd2);
        check("mul",    dut.regs[5],  19'd15);
        check("div",    dut.regs[6],  19'd1);
        check("div0",   dut.regs[8],  19'h7FFFF);
        check("subneg", dut.regs[7],  19'h7FFFE);
        check("inc",    dut.regs[9],  19'd6);
        check("dec",    dut.regs[10], 19'd2);
        check("and",    dut.regs[11], 19'd1);
        check("or",     dut.regs[12], 19'd7);
        check("xor",    dut.regs[13], 19'd6);
        check("not",    dut.regs[14], 19'h7FFFA);
        check("mulwrap", dut.regs[15], 19'h7F801);
        check("nop_pc", dut.pc_q, 19'd17);

        // Mid-run reset: state clears asynchronously
        @(posedge clk); #2 reset = 1'b0;
        #1;
        check("midrst_pc", dut.pc_q, 19'd0);
        check("midrst_r3", dut.regs[3], 19'd0);
        check("midrst_r15", dut.regs[15], 19'd0);

        // Branch / jump / call program
        clear_imem();
        imem[0]   = ldi(1, 4);
        imem[1]   = ldi(2, 4);
        imem[2]   = br(11, 1, 2, 3);
        imem[5]   = br(11, 1, 2, -2);
        imem[3]   = br(12, 1, 2, 7);
        imem[4]   = jt(10, 100);
        imem[100] = jt(13, 200);
        imem[200] = jt(14, 0);
        imem[102] = jt(10, 102);
        @(negedge clk) reset = 1'b1;
        tick(2);
        tick(1); check("beq_fwd",  dut.pc_q, 19'd5);
        tick(1); check("beq_back", dut.pc_q, 19'd3);
        tick(1); check("bne_fall", dut.pc_q, 19'd4);
        tick(1); check("jmp",      dut.pc_q, 19'd100);
        tick(1); check("call",     dut.pc_q, 19'd200);
        tick(1); check("ret",      dut.pc_q, 19'd101);
        tick(1); check("nop2",     dut.pc_q, 19'd102);

        // Nine nested calls then returns: stack wraps, first push lost
        pulse_reset_then_release();
        reset = 1'b0;
        clear_imem();
        for (int i = 0; i < 9; i++) imem[10 * i] = jt(13, 10 * (i + 1));
        imem[90] = jt(14, 0);
        for (int i = 1; i < 9; i++) imem[10 * i + 1] = jt(14, 0);
        @(negedge clk) reset = 1'b1;
        tick(9);  check("call9", dut.pc_q, 19'd90);
        tick(1);  check("ret1",  dut.pc_q, 19'd81);
        tick(7);  check("ret8",  dut.pc_q, 19'd11);
        tick(1);  check("ret9_wrap", dut.pc_q, 19'd81);

        // Load/store with address aliasing
        pulse_reset_then_release();
        reset = 1'b0;
        clear_imem();
        imem[0] = ldi(1, 7);
        imem[1] = ldi(2, 42);
        imem[2] = r_op(16, 2, 1, 0);
        imem[3] = r_op(15, 3, 1, 0);
        imem[4] = ldi(4, 263);
        imem[5] = ldi(5, 99);
        imem[6] = r_op(16, 5, 4, 0);
        imem[7] = r_op(15, 6, 1, 0);
        imem[8] = jt(10, 8);
        @(negedge clk) reset = 1'b1;
        tick(9);
        check("ld_st",  dut.regs[3], 19'd42);
        check("alias",  dut.regs[6], 19'd99);
        check("mem_pc", dut.pc_q, 19'd8);

        @(negedge clk);
        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
